// File: rtl/exc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// exc_ctrl_pkg
// Shared control encodings for the exception controller:
//   - FSM state encoding (IDLE / SAVE / REDIRECT / RETURN)
//   - ExcCode values (INT 0, Sys 1, Unimpl 2, Ovf 3)
//   - default NPC select codes for the handler vector and EPC
//   - nesting depth limit
//   - helper converting an ExcCode into the CP0 Signal one-hot
// -----------------------------------------------------------------------------
package exc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SAVE     = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_RETURN   = 2'd3
  } exc_state_e;

  localparam logic [1:0] EXC_INT    = 2'd0;
  localparam logic [1:0] EXC_SYS    = 2'd1;
  localparam logic [1:0] EXC_UNIMPL = 2'd2;
  localparam logic [1:0] EXC_OVF    = 2'd3;

  localparam logic [2:0] HANDLER_SEL_DEFAULT = 3'd4;
  localparam logic [2:0] EPC_SEL_DEFAULT     = 3'd5;

  // Deepest nesting level that can be tracked.
  localparam logic [2:0] DEPTH_MAX = 3'd7;

  // ExcCode -> CP0 Signal bit: [0]INT [1]Sys [2]Unimpl [3]Ovf
  function automatic logic [3:0] exc_onehot(input logic [1:0] code);
    logic [3:0] oh;
    case (code)
      EXC_INT:    oh = 4'b0001;
      EXC_SYS:    oh = 4'b0010;
      EXC_UNIMPL: oh = 4'b0100;
      EXC_OVF:    oh = 4'b1000;
      default:    oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// -----------------------------------------------------------------------------
// exc_prio_enc
// Combinational priority encoder with interrupt masking.
// Priority: ovf > unimpl > sys > int > eret. Exactly one winner is reported.
// The interrupt only counts when enabled (Status[0]) and the nesting depth
// still has room; sys/unimpl/ovf are never masked.
// Ports:
//   int_req, sys_req, unimpl_req, ovf_req, eret_req : raw request levels
//   int_en      : Status[0] interrupt enable
//   depth       : current nesting depth
//   exc_valid   : an exception wins this sample
//   exc_code    : ExcCode of the winning exception (0 when none)
//   eret_win    : eret wins (no exception pending)
// -----------------------------------------------------------------------------
module exc_prio_enc
  import exc_ctrl_pkg::*;
(
  input  logic       int_req,
  input  logic       sys_req,
  input  logic       unimpl_req,
  input  logic       ovf_req,
  input  logic       eret_req,
  input  logic       int_en,
  input  logic [2:0] depth,
  output logic       exc_valid,
  output logic [1:0] exc_code,
  output logic       eret_win
);

  logic int_ok;

  // Interrupt qualification: enabled and not already at full nesting depth.
  always_comb begin
    if (int_req && int_en && (depth != DEPTH_MAX)) begin
      int_ok = 1'b1;
    end else begin
      int_ok = 1'b0;
    end
  end

  // Fixed-priority select; an exception always beats a simultaneous eret.
  always_comb begin
    exc_valid = 1'b0;
    exc_code  = EXC_INT;
    eret_win  = 1'b0;
    if (ovf_req) begin
      exc_valid = 1'b1;
      exc_code  = EXC_OVF;
    end else if (unimpl_req) begin
      exc_valid = 1'b1;
      exc_code  = EXC_UNIMPL;
    end else if (sys_req) begin
      exc_valid = 1'b1;
      exc_code  = EXC_SYS;
    end else if (int_ok) begin
      exc_valid = 1'b1;
      exc_code  = EXC_INT;
    end else if (eret_req) begin
      eret_win  = 1'b1;
    end else begin
      eret_win  = 1'b0;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// -----------------------------------------------------------------------------
// exc_ctrl
// Exception / eret sequencer for a multi-cycle CPU with CP0.
// An accepted exception runs IDLE -> SAVE -> REDIRECT -> IDLE:
//   SAVE     : CP0 Signal one-hot, EPC write with latched PC, flush
//   REDIRECT : PC <- handler vector (pc_src = HANDLER_SEL), flush
// An accepted eret runs IDLE -> RETURN -> IDLE:
//   RETURN   : CP0 eret, PC <- EPC (pc_src = EPC_SEL), flush
// Requests are sampled only in IDLE with stall low. A nesting depth counter
// (0..7) tracks exception entry/return; over/underflow sets sticky nest_err.
// Every output is a flop loaded from the next-state decode, so nothing
// combinational reaches an output from the request inputs, and the async
// reset kills any strobe in the same cycle.
// Ports:
//   clk, rst (async, active-low)
//   int_req, sys_req, unimpl_req, ovf_req, eret_req, exc_pc, stall, status
//   cp0_signal, epc_wr, epc_in, eret_o, pc_src, pc_wr, flush, busy, depth,
//   nest_err
// -----------------------------------------------------------------------------
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [2:0] HANDLER_SEL = HANDLER_SEL_DEFAULT,
  parameter logic [2:0] EPC_SEL     = EPC_SEL_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_req,
  input  logic        sys_req,
  input  logic        unimpl_req,
  input  logic        ovf_req,
  input  logic        eret_req,
  input  logic [31:0] exc_pc,
  input  logic        stall,
  input  logic [31:0] status,
  output logic [3:0]  cp0_signal,
  output logic        epc_wr,
  output logic [31:0] epc_in,
  output logic        eret_o,
  output logic [2:0]  pc_src,
  output logic        pc_wr,
  output logic        flush,
  output logic        busy,
  output logic [2:0]  depth,
  output logic        nest_err
);

  // Only the interrupt-enable bit of Status matters here.
  logic status_unused;
  assign status_unused = ^status[31:1];

  // Priority encoder outputs
  logic       exc_valid;
  logic [1:0] exc_code;
  logic       eret_win;

  // State and latched context
  exc_state_e  state_q, state_d;
  logic [1:0]  code_q, code_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  depth_q, depth_d;
  logic        nest_err_q, nest_err_d;

  // Registered output strobes
  logic [3:0]  cp0_signal_q, cp0_signal_d;
  logic        epc_wr_q, epc_wr_d;
  logic        eret_q, eret_d;
  logic [2:0]  pc_src_q, pc_src_d;
  logic        pc_wr_q, pc_wr_d;
  logic        flush_q, flush_d;
  logic        busy_q, busy_d;

  exc_prio_enc u_prio (
    .int_req    (int_req),
    .sys_req    (sys_req),
    .unimpl_req (unimpl_req),
    .ovf_req    (ovf_req),
    .eret_req   (eret_req),
    .int_en     (status[0]),
    .depth      (depth_q),
    .exc_valid  (exc_valid),
    .exc_code   (exc_code),
    .eret_win   (eret_win)
  );

  // Next-state, context latch and nesting-depth bookkeeping.
  // Depth moves on the transition into SAVE/RETURN so the new value is
  // already visible while the corresponding strobes are up.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    pc_d       = pc_q;
    depth_d    = depth_q;
    nest_err_d = nest_err_q;
    case (state_q)
      ST_IDLE: begin
        if (stall) begin
          state_d = ST_IDLE;
        end else if (exc_valid) begin
          state_d = ST_SAVE;
          code_d  = exc_code;
          pc_d    = exc_pc;
          if (depth_q == DEPTH_MAX) begin
            nest_err_d = 1'b1;
          end else begin
            depth_d = depth_q + 3'd1;
          end
        end else if (eret_win) begin
          state_d = ST_RETURN;
          if (depth_q == 3'd0) begin
            nest_err_d = 1'b1;
          end else begin
            depth_d = depth_q - 3'd1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SAVE:     state_d = ST_REDIRECT;
      ST_REDIRECT: state_d = ST_IDLE;
      ST_RETURN:   state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Output decode of the next state, loaded into the output flops.
  always_comb begin
    cp0_signal_d = 4'b0000;
    epc_wr_d     = 1'b0;
    eret_d       = 1'b0;
    pc_src_d     = 3'd0;
    pc_wr_d      = 1'b0;
    flush_d      = 1'b0;
    busy_d       = 1'b1;
    case (state_d)
      ST_IDLE: begin
        busy_d = 1'b0;
      end
      ST_SAVE: begin
        cp0_signal_d = exc_onehot(code_d);
        epc_wr_d     = 1'b1;
        flush_d      = 1'b1;
      end
      ST_REDIRECT: begin
        pc_src_d = HANDLER_SEL;
        pc_wr_d  = 1'b1;
        flush_d  = 1'b1;
      end
      ST_RETURN: begin
        eret_d   = 1'b1;
        pc_src_d = EPC_SEL;
        pc_wr_d  = 1'b1;
        flush_d  = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State, context and output registers; reset aborts any sequence at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      code_q       <= 2'd0;
      pc_q         <= 32'd0;
      depth_q      <= 3'd0;
      nest_err_q   <= 1'b0;
      cp0_signal_q <= 4'b0000;
      epc_wr_q     <= 1'b0;
      eret_q       <= 1'b0;
      pc_src_q     <= 3'd0;
      pc_wr_q      <= 1'b0;
      flush_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      pc_q         <= pc_d;
      depth_q      <= depth_d;
      nest_err_q   <= nest_err_d;
      cp0_signal_q <= cp0_signal_d;
      epc_wr_q     <= epc_wr_d;
      eret_q       <= eret_d;
      pc_src_q     <= pc_src_d;
      pc_wr_q      <= pc_wr_d;
      flush_q      <= flush_d;
      busy_q       <= busy_d;
    end
  end

  assign cp0_signal = cp0_signal_q;
  assign epc_wr     = epc_wr_q;
  assign epc_in     = pc_q;
  assign eret_o     = eret_q;
  assign pc_src     = pc_src_q;
  assign pc_wr      = pc_wr_q;
  assign flush      = flush_q;
  assign busy       = busy_q;
  assign depth      = depth_q;
  assign nest_err   = nest_err_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exc_ctrl
// Scoreboard bench: the driver applies stimulus and a reference model pushes
// the expected output vectors (with the cycle they must appear in) into a
// queue; an independent monitor pops and compares whenever the DUT shows a
// strobe, and checks the quiet state otherwise.
// -----------------------------------------------------------------------------
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        int_req, sys_req, unimpl_req, ovf_req, eret_req, stall;
  logic [31:0] exc_pc, status;
  logic [3:0]  cp0_signal;
  logic        epc_wr, eret_o, pc_wr, flush, busy, nest_err;
  logic [31:0] epc_in;
  logic [2:0]  pc_src, depth;

  always #5 clk = ~clk;

  exc_ctrl dut (
    .clk(clk), .rst(rst),
    .int_req(int_req), .sys_req(sys_req), .unimpl_req(unimpl_req),
    .ovf_req(ovf_req), .eret_req(eret_req), .exc_pc(exc_pc),
    .stall(stall), .status(status),
    .cp0_signal(cp0_signal), .epc_wr(epc_wr), .epc_in(epc_in),
    .eret_o(eret_o), .pc_src(pc_src), .pc_wr(pc_wr), .flush(flush),
    .busy(busy), .depth(depth), .nest_err(nest_err)
  );

  typedef struct {
    int          cyc;
    logic [47:0] vec;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  // reference model state
  int          m_depth = 0;
  int          m_busy  = 0;
  logic        m_nest  = 1'b0;
  logic [31:0] m_pc    = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [47:0] pack(input logic [3:0] c, input logic ew,
                                       input logic [31:0] ei, input logic er,
                                       input logic [2:0] ps, input logic pw,
                                       input logic fl, input logic bs,
                                       input logic [2:0] d, input logic ne);
    return {c, ew, ei, er, ps, pw, fl, bs, d, ne};
  endfunction

  function automatic logic [47:0] actual();
    return pack(cp0_signal, epc_wr, epc_in, eret_o, pc_src, pc_wr, flush,
                busy, depth, nest_err);
  endfunction

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference model: decides what the next sampling edge does, from the rules
  // (priority, masking, nesting limits) using plain integers.
  task automatic model_step();
    int   w;
    exp_t r;
    if (m_busy > 0) begin
      m_busy--;
    end else if (!stall) begin
      w = -1;
      if (ovf_req) w = 3;
      else if (unimpl_req) w = 2;
      else if (sys_req) w = 1;
      else if (int_req && status[0] && m_depth < 7) w = 0;
      if (w >= 0) begin
        if (m_depth == 7) m_nest = 1'b1;
        else m_depth++;
        m_pc  = exc_pc;
        r.cyc = cyc + 1;
        r.vec = pack(4'b0001 << w, 1'b1, m_pc, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1,
                     m_depth[2:0], m_nest);
        exp_q.push_back(r);
        r.cyc = cyc + 2;
        r.vec = pack(4'b0000, 1'b0, m_pc, 1'b0, 3'd4, 1'b1, 1'b1, 1'b1,
                     m_depth[2:0], m_nest);
        exp_q.push_back(r);
        m_busy = 2;
      end else if (eret_req) begin
        if (m_depth == 0) m_nest = 1'b1;
        else m_depth--;
        r.cyc = cyc + 1;
        r.vec = pack(4'b0000, 1'b0, m_pc, 1'b1, 3'd5, 1'b1, 1'b1, 1'b1,
                     m_depth[2:0], m_nest);
        exp_q.push_back(r);
        m_busy = 1;
      end
    end
  endtask

  // Monitor: compare every presented strobe against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      if (epc_wr || pc_wr || eret_o || flush || (cp0_signal != 4'b0000)) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe: got %h want none", actual());
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("latency", 48'(cyc), 48'(e.cyc));
          check("outputs", actual(), e.vec);
        end
      end else if (exp_q.size() > 0) begin
        if (exp_q[0].cyc <= cyc) begin
          exp_t e;
          e = exp_q.pop_front();
          total++;
          bad++;
          $display("FAIL missing_strobe: got %h want %h", actual(), e.vec);
        end
      end else begin
        check("idle", actual(), pack(4'b0000, 1'b0, m_pc, 1'b0, 3'd0, 1'b0,
                                     1'b0, 1'b0, m_depth[2:0], m_nest));
      end
    end
  end

  task automatic drive(input logic i, input logic s, input logic u, input logic o,
                       input logic e, input logic [31:0] pc, input logic st,
                       input logic [31:0] stat);
    @(negedge clk);
    #1;
    int_req = i; sys_req = s; unimpl_req = u; ovf_req = o; eret_req = e;
    exc_pc = pc; stall = st; status = stat;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    int_req = 1'b0; sys_req = 1'b0; unimpl_req = 1'b0; ovf_req = 1'b0;
    eret_req = 1'b0; stall = 1'b0; exc_pc = 32'd0; status = 32'd0;
    exp_q.delete();
    m_depth = 0; m_busy = 0; m_nest = 1'b0; m_pc = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    int_req = 1'b0; sys_req = 1'b0; unimpl_req = 1'b0; ovf_req = 1'b0;
    eret_req = 1'b0; stall = 1'b0; exc_pc = 32'd0; status = 32'd0;
    repeat (3) @(posedge clk);
    #2 check("reset_state", actual(), 48'd0);
    @(negedge clk);
    #1 rst = 1'b1;

    // overflow at 0x3010: SAVE with Ovf one-hot, then handler redirect
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_3010, 1'b0, 32'h1);
    idle(4);
    // int + sys together with interrupts enabled: only Sys reported
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_4000, 1'b0, 32'h1);
    idle(4);
    // masked interrupt held for 10 cycles: never busy
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_5000, 1'b0, 32'hFFFF_FFFE);
      @(posedge clk);
      #1 check("masked_int_busy", {47'd0, busy}, 48'd0);
    end
    // stall blocks sampling of an overflow
    for (int k = 0; k < 4; k++)
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_6000, 1'b1, 32'h1);
    idle(2);
    // exception and eret together: exception wins, eret dropped
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_7000, 1'b0, 32'h1);
    idle(4);
    // unwind depth 3 -> 0 then one extra eret (underflow)
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_8000, 1'b0, 32'h0);
      idle(3);
    end
    check("underflow_nest", {45'd0, depth, nest_err}, {45'd0, 3'd0, 1'b1});

    // eight nested syscalls saturate depth at 7, then interrupt ignored
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1000 + 32'(k * 4), 1'b0, 32'h1);
      idle(3);
    end
    for (int k = 0; k < 5; k++)
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_9000, 1'b0, 32'h1);
    idle(2);
    check("saturate_nest", {44'd0, busy, depth, nest_err}, {44'd0, 1'b0, 3'd7, 1'b1});

    // reset in the middle of SAVE aborts the sequence
    apply_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_A000, 1'b0, 32'h1);
    @(posedge clk);
    #2 check("save_epc_wr", {47'd0, epc_wr}, 48'd1);
    rst = 1'b0;
    ovf_req = 1'b0;
    exp_q.delete();
    m_depth = 0; m_busy = 0; m_nest = 1'b0; m_pc = 32'd0;
    #1 check("reset_abort", actual(), 48'd0);
    @(posedge clk);
    #2 check("no_redirect", {47'd0, pc_wr}, 48'd0);
    @(negedge clk);
    #1 rst = 1'b1;
    idle(3);

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 3) == 0,
            $urandom);
    end
    idle(6);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL have parameter HANDLER_SEL, default 3'd4, pc_src code selecting the exception handler vector in NPC.
REQ-002 SHALL have parameter EPC_SEL, default 3'd5, pc_src code selecting EPC in NPC.
REQ-003 SHALL have ports, clock and reset first:
 clk  in  1  single clock, all state on posedge
 rst  in  1  asynchronous, active-low reset
 int_req  in  1  external interrupt, level
 sys_req  in  1  syscall detected
 unimpl_req  in  1  unimplemented opcode
 ovf_req  in  1  arithmetic overflow
 eret_req  in  1  eret decoded
 exc_pc  in  32  PC of the faulting/eret instruction
 stall  in  1  pipeline stall, blocks request sampling
 status  in  32  CP0 Status (StatusOut)
 cp0_signal  out  4  one-hot to CP0 Signal: [0]INT [1]Sys [2]Unimpl [3]Ovf
 epc_wr  out  1  CP0 EPCWr
 epc_in  out  32  CP0 EPCIn
 eret_o  out  1  CP0 eret
 pc_src  out  3  NPC select override
 pc_wr  out  1  PC write enable override
 flush  out  1  flush IF/ID/EX
 busy  out  1  state != IDLE
 depth  out  3  current nesting depth
 nest_err  out  1  sticky nesting violation

Function
REQ-004 SHALL implement FSM states IDLE, SAVE, REDIRECT, RETURN.
REQ-005 In IDLE with stall=0, SHALL sample requests; with stall=1, SHALL stay in IDLE and ignore all requests.
REQ-006 Priority SHALL be ovf > unimpl > sys > int > eret; exactly one winner per sample.
REQ-007 int_req SHALL count as a request only when status[0]=1 and depth<7; sys/unimpl/ovf are never masked.
REQ-008 On a winning exception: IDLE->SAVE; winner code and exc_pc SHALL be latched in registers.
REQ-009 In SAVE (one cycle): cp0_signal = latched one-hot, epc_wr=1, epc_in = latched PC, flush=1; depth SHALL increment, saturating at 7.
REQ-010 If depth==7 on entry to SAVE, nest_err SHALL set (sticky) and depth SHALL stay 7.
REQ-011 SAVE->REDIRECT unconditionally; REDIRECT (one cycle): pc_src=HANDLER_SEL, pc_wr=1, flush=1; then ->IDLE.
REQ-012 On eret winning: IDLE->RETURN; RETURN (one cycle): eret_o=1, pc_src=EPC_SEL, pc_wr=1, flush=1; depth SHALL decrement; ->IDLE.
REQ-013 eret at depth 0 SHALL still perform RETURN, leave depth 0, and set nest_err.
REQ-014 Exception and eret sampled together: exception SHALL win, eret is dropped.
REQ-015 Requests arriving while busy=1 SHALL be ignored (sources hold their level until flushed or retired).
REQ-016 Outside the states above, cp0_signal=0, epc_wr=0, eret_o=0, pc_wr=0, flush=0, pc_src=3'd0, epc_in=latched PC.
REQ-017 Exception-to-handler latency SHALL be exactly 2 cycles after the sampling edge; eret latency 1 cycle.
REQ-018 All outputs SHALL be registered-state decodes with no combinational path from request inputs.

Reset
REQ-019 On rst=0, SHALL force state IDLE, depth=0, nest_err=0, latched code=0, latched PC=0, all strobes 0, pc_src=0, busy=0.
REQ-020 Reset asserted mid-SAVE/REDIRECT/RETURN SHALL abort immediately with no further strobes.

Structure
REQ-021 State encodings, ExcCode values (INT 0, Sys 1, Unimpl 2, Ovf 3), and HANDLER_SEL/EPC_SEL defaults SHALL live in the shared control-encode define file.
REQ-022 One sub-module, exc_prio_enc (combinational priority encoder plus masking), SHALL be instantiated.

Verification
REQ-023 ovf_req=1, exc_pc=32'h0000_3010 in IDLE -> next cycle cp0_signal=4'b1000, epc_wr=1, epc_in=32'h0000_3010; following cycle pc_src=3'd4, pc_wr=1; depth 0->1.
REQ-024 int_req=1, sys_req=1 same cycle, status[0]=1 -> cp0_signal=4'b0010 only.
REQ-025 int_req=1, status[0]=0 -> stays IDLE, busy=0 for 10 cycles.
REQ-026 depth=1, eret_req=1 -> next cycle eret_o=1, pc_src=3'd5, flush=1; depth=0; second eret -> nest_err=1.
REQ-027 Eight nested sys_req entries -> depth saturates at 7, nest_err=1 on eighth; int_req ignored at depth 7.
REQ-028 rst=0 asserted during SAVE -> epc_wr drops same cycle, no REDIRECT, depth=0.
